// File: rtl/wb_burst_master.sv
// Wishbone burst master: turns a single command (address, beat count,
// direction) into an incrementing-burst Wishbone cycle toward the SDRAM
// controller, pulling write beats from a stream and pushing read beats out.
// Every output comes straight from a register.
module wb_burst_master #(
  parameter int APP_AW = 26,
  parameter int dw     = 32,
  parameter int bl     = 9,
  parameter int TMO_W  = 10
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [APP_AW-1:0] cmd_addr,
  input  logic [bl-1:0]     cmd_len,
  input  logic [dw-1:0]     wr_data,
  input  logic [dw/8-1:0]   wr_sel,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [dw-1:0]     rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [APP_AW-1:0] wb_addr_o,
  output logic [dw-1:0]     wb_dat_o,
  output logic [dw/8-1:0]   wb_sel_o,
  output logic [2:0]        wb_cti_o,
  input  logic              wb_ack_i,
  input  logic [dw-1:0]     wb_dat_i
);

  localparam int SW = dw / 8;
  localparam logic [APP_AW-1:0] ADDR_ONE  = {{(APP_AW-1){1'b0}}, 1'b1};
  localparam logic [APP_AW-1:0] ADDR_INC  = APP_AW'(SW);
  // Clears the sub-word byte offset of the start address.
  localparam logic [APP_AW-1:0] ADDR_MASK = ~(ADDR_INC - ADDR_ONE);
  localparam logic [bl-1:0]     CNT_ZERO  = {bl{1'b0}};
  localparam logic [bl-1:0]     CNT_ONE   = {{(bl-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0]  TMO_ZERO  = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0]  TMO_ONE   = {{(TMO_W-1){1'b0}}, 1'b1};
  // Abort when the counter is about to reach all-ones, so stb stays up for
  // exactly 2^TMO_W-1 unacknowledged cycles.
  localparam logic [TMO_W-1:0]  TMO_LAST  = {{(TMO_W-1){1'b1}}, 1'b0};
  localparam logic [SW-1:0]     SEL_ONES  = {SW{1'b1}};
  localparam logic [2:0]        CTI_CLASSIC = 3'b000;
  localparam logic [2:0]        CTI_INCR    = 3'b010;
  localparam logic [2:0]        CTI_EOB     = 3'b111;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_LOAD = 3'd1,
    WR_BEAT = 3'd2,
    RD_BEAT = 3'd3,
    FIN     = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [APP_AW-1:0] addr_r, addr_s;
  logic [bl-1:0]     cnt_r, cnt_s;
  logic [TMO_W-1:0]  tmo_r, tmo_s;
  logic              cyc_r, cyc_s, stb_r, stb_s, we_r, we_s;
  logic [dw-1:0]     dat_r, dat_s, rd_data_r, rd_data_s;
  logic [SW-1:0]     sel_r, sel_s;
  logic [2:0]        cti_r, cti_s;
  logic              cmd_ready_r, cmd_ready_s, wr_ready_r, wr_ready_s;
  logic              rd_valid_r, rd_valid_s, done_r, done_s, err_r, err_s;

  // Next-state and next-output computation for the command FSM.
  always_comb begin
    state_s    = state_r;
    addr_s     = addr_r;
    cnt_s      = cnt_r;
    tmo_s      = tmo_r;
    cyc_s      = cyc_r;
    stb_s      = stb_r;
    we_s       = we_r;
    dat_s      = dat_r;
    sel_s      = sel_r;
    wr_ready_s = 1'b0;
    rd_data_s  = rd_data_r;
    rd_valid_s = 1'b0;
    err_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          addr_s = cmd_addr & ADDR_MASK;
          cnt_s  = cmd_len;
          tmo_s  = TMO_ZERO;
          if (cmd_len == CNT_ZERO) begin
            state_s = FIN;
          end else if (cmd_wr) begin
            state_s    = WR_LOAD;
            cyc_s      = 1'b1;
            stb_s      = 1'b0;
            we_s       = 1'b1;
            wr_ready_s = 1'b1;
          end else begin
            state_s = RD_BEAT;
            cyc_s   = 1'b1;
            stb_s   = 1'b1;
            we_s    = 1'b0;
            sel_s   = SEL_ONES;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WR_LOAD: begin
        if (wr_valid && wr_ready_r) begin
          dat_s   = wr_data;
          sel_s   = wr_sel;
          stb_s   = 1'b1;
          we_s    = 1'b1;
          tmo_s   = TMO_ZERO;
          state_s = WR_BEAT;
        end else begin
          wr_ready_s = 1'b1;
        end
      end
      WR_BEAT, RD_BEAT: begin
        if (wb_ack_i) begin
          cnt_s  = cnt_r - CNT_ONE;
          addr_s = addr_r + ADDR_INC;
          tmo_s  = TMO_ZERO;
          if (state_r == RD_BEAT) begin
            rd_data_s  = wb_dat_i;
            rd_valid_s = 1'b1;
          end else begin
            rd_valid_s = 1'b0;
          end
          if (cnt_r == CNT_ONE) begin
            cyc_s   = 1'b0;
            stb_s   = 1'b0;
            we_s    = 1'b0;
            state_s = FIN;
          end else if (state_r == WR_BEAT) begin
            stb_s      = 1'b0;
            wr_ready_s = 1'b1;
            state_s    = WR_LOAD;
          end else begin
            state_s = RD_BEAT;
          end
        end else if (tmo_r == TMO_LAST) begin
          cyc_s   = 1'b0;
          stb_s   = 1'b0;
          we_s    = 1'b0;
          err_s   = 1'b1;
          state_s = FIN;
        end else begin
          tmo_s = tmo_r + TMO_ONE;
        end
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        cyc_s   = 1'b0;
        stb_s   = 1'b0;
        we_s    = 1'b0;
      end
    endcase
    cmd_ready_s = (state_s == IDLE);
    done_s      = (state_s == FIN);
    if (!cyc_s) begin
      cti_s = CTI_CLASSIC;
    end else if (cnt_s == CNT_ONE) begin
      cti_s = CTI_EOB;
    end else begin
      cti_s = CTI_INCR;
    end
  end

  // State and output registers; reset drops any bus cycle immediately.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r     <= IDLE;
      addr_r      <= {APP_AW{1'b0}};
      cnt_r       <= CNT_ZERO;
      tmo_r       <= TMO_ZERO;
      cyc_r       <= 1'b0;
      stb_r       <= 1'b0;
      we_r        <= 1'b0;
      dat_r       <= {dw{1'b0}};
      sel_r       <= {SW{1'b0}};
      cti_r       <= CTI_CLASSIC;
      cmd_ready_r <= 1'b0;
      wr_ready_r  <= 1'b0;
      rd_data_r   <= {dw{1'b0}};
      rd_valid_r  <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      addr_r      <= addr_s;
      cnt_r       <= cnt_s;
      tmo_r       <= tmo_s;
      cyc_r       <= cyc_s;
      stb_r       <= stb_s;
      we_r        <= we_s;
      dat_r       <= dat_s;
      sel_r       <= sel_s;
      cti_r       <= cti_s;
      cmd_ready_r <= cmd_ready_s;
      wr_ready_r  <= wr_ready_s;
      rd_data_r   <= rd_data_s;
      rd_valid_r  <= rd_valid_s;
      done_r      <= done_s;
      err_r       <= err_s;
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign wr_ready  = wr_ready_r;
  assign rd_data   = rd_data_r;
  assign rd_valid  = rd_valid_r;
  assign done      = done_r;
  assign err       = err_r;
  assign wb_cyc_o  = cyc_r;
  assign wb_stb_o  = stb_r;
  assign wb_we_o   = we_r;
  assign wb_addr_o = addr_r;
  assign wb_dat_o  = dat_r;
  assign wb_sel_o  = sel_r;
  assign wb_cti_o  = cti_r;

endmodule
